// File: rtl/regfile_param.sv
// regfile_param: parametrised 2-read / 1-write register file for the single-cycle datapath.
// Register 0 always reads as zero. A small clear engine walks registers 1..Depth-1 and
// zeroes them, after reset or whenever 'clear' is requested while idle.
// Optional feature: define RF_BYPASS_EN to forward the write data to a read port
// that addresses the register being written in the same cycle.
`timescale 1ns/1ps

module regfile_param #(
  parameter int Width = 32,
  parameter int Depth = 32,
  localparam int AW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             RegWrite,
  input  logic [AW-1:0]    W1,
  input  logic [Width-1:0] WD1,
  input  logic [AW-1:0]    R1,
  input  logic [AW-1:0]    R2,
  output logic [Width-1:0] RD1,
  output logic [Width-1:0] RD2,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Index of the last register the clear engine has to zero.
  localparam logic [AW-1:0] LastIdx = AW'(Depth - 1);

  state_t           r_state;
  logic [AW-1:0]    r_clrIdx;
  logic [Width-1:0] r_regs [Depth];

  logic             w_busy;
  logic             w_writeEn;
  logic [Width-1:0] w_rd1;
  logic [Width-1:0] w_rd2;

  // busy is taken straight from the state register so it is glitch-free.
  assign w_busy = (r_state == CLEAR);

  // A normal write only lands when idle, no clear is being requested
  // (clear wins over a simultaneous write) and the target is not register 0.
  assign w_writeEn = (r_state == IDLE) && !clear && RegWrite && (W1 != '0);

  // Clear engine: reset or a clear request starts at index 1 (register 0 needs
  // no clearing) and walks to Depth-1; a clear request while already clearing is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= CLEAR;
      r_clrIdx <= AW'(1);
    end else begin
      case (r_state)
        IDLE: begin
          if (clear) begin
            r_state  <= CLEAR;
            r_clrIdx <= AW'(1);
          end
        end
        CLEAR: begin
          r_clrIdx <= r_clrIdx + AW'(1);
          if (r_clrIdx == LastIdx) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state  <= CLEAR;
          r_clrIdx <= AW'(1);
        end
      endcase
    end
  end

  // Storage array has no reset of its own; the clear engine zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (r_state == CLEAR) begin
      r_regs[r_clrIdx] <= '0;
    end else if (w_writeEn) begin
      r_regs[W1] <= WD1;
    end
  end

  // Read port 1: zero while busy or for register 0, otherwise the stored value (or forwarded write data).
  always_comb begin
    w_rd1 = '0;
    if (!w_busy && (R1 != '0)) begin
      w_rd1 = r_regs[R1];
`ifdef RF_BYPASS_EN
      if (RegWrite && (W1 == R1)) begin
        w_rd1 = WD1;
      end
`endif
    end
  end

  // Read port 2: identical behaviour to port 1, evaluated independently.
  always_comb begin
    w_rd2 = '0;
    if (!w_busy && (R2 != '0)) begin
      w_rd2 = r_regs[R2];
`ifdef RF_BYPASS_EN
      if (RegWrite && (W1 == R2)) begin
        w_rd2 = WD1;
      end
`endif
    end
  end

  assign RD1  = w_rd1;
  assign RD2  = w_rd2;
  assign busy = w_busy;

endmodule
